// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int BCD_MAX  = 9999;
  localparam int N_DIGITS = 4;

  typedef struct packed {
    logic        ovf;
    logic [15:0] val;
  } sat_t;

  // Clamp to the largest value four BCD digits can show and flag the clamp.
  function automatic sat_t sat_value(input logic [15:0] v);
    sat_t r;
    if (v > 16'(BCD_MAX)) begin
      r.ovf = 1'b1;
      r.val = 16'(BCD_MAX);
    end else begin
      r.ovf = 1'b0;
      r.val = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_converter_if.sv
// Start/value request and registered BCD result bundle of the converter.
interface bcd_digit_converter_if #(
  parameter int BIN_W = 14
);
  logic             start;
  logic [BIN_W-1:0] value;
  logic             busy;
  logic             done;
  logic             ovf;
  logic [3:0]       num3;
  logic [3:0]       num2;
  logic [3:0]       num1;
  logic [3:0]       num0;

  modport master (
    output start, value,
    input  busy, done, ovf, num3, num2, num1, num0
  );

  modport slave (
    input  start, value,
    output busy, done, ovf, num3, num2, num1, num0
  );
endinterface

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every nibble >= 5, then shift left
// by one with the next binary bit entering at the bottom.
module bcd_dabble_step
  import bcd_pkg::*;
(
  input  logic [15:0] bcd_in,
  input  logic        shift_in,
  output logic [15:0] bcd_out
);

  logic [15:0] adj;
  logic        unused_top_bit;

  for (genvar i = 0; i < N_DIGITS; i++) begin : g_nib
    logic [3:0] nib;
    assign nib            = bcd_in[4*i +: 4];
    assign adj[4*i +: 4]  = (nib >= 4'd5) ? nib + 4'd3 : nib;
  end

  // Final digits are <= 9, so the bit shifted out of the thousands nibble is always 0.
  assign unused_top_bit = adj[15];
  assign bcd_out        = {adj[14:0], shift_in};

endmodule

// File: rtl/bcd_digit_converter.sv
// Sequential binary-to-BCD converter; the four digit registers change only
// on the done cycle so the display never shows a partial result.
//
//   state | meaning
//   IDLE  | waiting for start; captures clamped value on start
//   SHIFT | one dabble step per clock, BIN_W steps in total
//   DONE  | done pulse; new digits and ovf are visible this cycle
module bcd_digit_converter
  import bcd_pkg::*;
#(
  parameter int BIN_W = 14
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bcd_digit_converter_if.slave bus
);

  localparam int CNT_W = $clog2(BIN_W + 1);

  state_t           state_q, state_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [15:0]      bcd_q, bcd_d;
  logic [15:0]      step_out;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_next_q, ovf_next_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic [15:0]      num_q, num_d;
  sat_t             sat;

  assign sat = sat_value(16'(bus.value));

  bcd_dabble_step u_step (
    .bcd_in   (bcd_q),
    .shift_in (bin_q[BIN_W-1]),
    .bcd_out  (step_out)
  );

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_next_d = ovf_next_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ovf_d      = ovf_q;
    num_d      = num_q;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (bus.start) begin
          bin_d      = BIN_W'(sat.val);
          ovf_next_d = sat.ovf;
          bcd_d      = '0;
          cnt_d      = CNT_W'(BIN_W);
          busy_d     = 1'b1;
          state_d    = SHIFT;
        end
      end

      SHIFT: begin
        bcd_d = step_out;
        bin_d = {bin_q[BIN_W-2:0], 1'b0};
        cnt_d = cnt_q - CNT_W'(1);
        // Results are loaded on the edge into DONE so they coincide with the done pulse.
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
          num_d   = step_out;
          ovf_d   = ovf_next_q;
          done_d  = 1'b1;
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_next_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      num_q      <= '0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ovf_next_q <= ovf_next_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      num_q      <= num_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.ovf  = ovf_q;
  assign bus.num3 = num_q[15:12];
  assign bus.num2 = num_q[11:8];
  assign bus.num1 = num_q[7:4];
  assign bus.num0 = num_q[3:0];

endmodule

// File: tb/tb_bcd_digit_converter.sv
// Directed bench for bcd_digit_converter: a 14-bit and a 16-bit instance.
module tb_bcd_digit_converter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  bcd_digit_converter_if #(.BIN_W(14)) if14 ();
  bcd_digit_converter_if #(.BIN_W(16)) if16 ();

  bcd_digit_converter #(.BIN_W(14)) u_dut14 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if14.slave)
  );

  bcd_digit_converter #(.BIN_W(16)) u_dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if16.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic int digits(input bit sel);
    if (sel) return int'({if16.num3, if16.num2, if16.num1, if16.num0});
    return int'({if14.num3, if14.num2, if14.num1, if14.num0});
  endfunction

  function automatic int busy_of(input bit sel);
    return sel ? int'(if16.busy) : int'(if14.busy);
  endfunction

  function automatic int done_of(input bit sel);
    return sel ? int'(if16.done) : int'(if14.done);
  endfunction

  function automatic int ovf_of(input bit sel);
    return sel ? int'(if16.ovf) : int'(if14.ovf);
  endfunction

  function automatic int to_bcd(input int v);
    return (v / 1000) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10);
  endfunction

  task automatic drive(input bit sel, input logic st, input int v);
    if (sel) begin
      if16.start = st;
      if16.value = 16'(v);
    end else begin
      if14.start = st;
      if14.value = 14'(v);
    end
  endtask

  // One conversion from IDLE: latency, busy through done, held outputs, result.
  task automatic conv(input bit sel, input int v, input int exp_digits, input int exp_ovf,
                      input string tag);
    int lat;
    int busy_bad;
    int hold_bad;
    int snap;
    snap     = digits(sel);
    busy_bad = 0;
    hold_bad = 0;
    @(negedge clk);
    drive(sel, 1'b1, v);
    @(negedge clk);
    drive(sel, 1'b0, 0);
    lat = 1;
    while (done_of(sel) == 0 && lat < 40) begin
      if (busy_of(sel) != 1) busy_bad++;
      if (digits(sel) != snap) hold_bad++;
      @(negedge clk);
      lat++;
    end
    if (busy_of(sel) != 1) busy_bad++;
    check({tag, "_latency"}, lat, sel ? 17 : 15);
    check({tag, "_busy_low_cycles"}, busy_bad, 0);
    check({tag, "_early_change"}, hold_bad, 0);
    check({tag, "_digits"}, digits(sel), exp_digits);
    check({tag, "_ovf"}, ovf_of(sel), exp_ovf);
    @(negedge clk);
    check({tag, "_done_width"}, done_of(sel), 0);
    check({tag, "_idle_busy"}, busy_of(sel), 0);
  endtask

  initial begin
    int ndone;
    int first_k;
    int got;
    int hold_bad;
    int w;

    drive(1'b0, 1'b0, 0);
    drive(1'b1, 1'b0, 0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy_of(0), 0);
    check("rst_done", done_of(0), 0);
    check("rst_ovf", ovf_of(0), 0);
    check("rst_digits", digits(0), 0);
    rst_n = 1'b1;
    @(negedge clk);

    conv(1'b0, 0,     16'h0000, 0, "v0");
    conv(1'b0, 1234,  16'h1234, 0, "v1234");
    conv(1'b0, 9999,  16'h9999, 0, "v9999");
    conv(1'b0, 1000,  16'h1000, 0, "v1000");
    conv(1'b0, 10000, 16'h9999, 1, "v10000_w14");
    conv(1'b1, 12345, 16'h9999, 1, "v12345_w16");
    conv(1'b1, 42,    16'h0042, 0, "v42_w16");
    conv(1'b0, 5678,  16'h5678, 0, "v5678");

    // Second start at cycle 5 of a running conversion must be dropped.
    @(negedge clk);
    drive(1'b0, 1'b1, 1111);
    @(negedge clk);
    drive(1'b0, 1'b0, 0);
    ndone    = 0;
    first_k  = 0;
    got      = 0;
    hold_bad = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 5) drive(1'b0, 1'b1, 2222);
      if (k == 6) drive(1'b0, 1'b0, 0);
      if (done_of(0) == 1) begin
        ndone++;
        if (ndone == 1) begin
          first_k = k;
          got     = digits(0);
        end
      end else if (ndone == 0 && digits(0) != 16'h5678) begin
        hold_bad++;
      end
      @(negedge clk);
    end
    check("ignore_done_count", ndone, 1);
    check("ignore_latency", first_k, 15);
    check("ignore_digits", got, 16'h1111);
    check("ignore_hold_5678", hold_bad, 0);

    // Asynchronous reset in cycle 7 of a conversion.
    @(negedge clk);
    drive(1'b0, 1'b1, 8888);
    @(negedge clk);
    drive(1'b0, 1'b0, 0);
    repeat (6) @(negedge clk);
    check("abort_busy_before", busy_of(0), 1);
    rst_n = 1'b0;
    #1;
    check("abort_digits", digits(0), 0);
    check("abort_busy", busy_of(0), 0);
    check("abort_done", done_of(0), 0);
    check("abort_digits_w16", digits(1), 0);
    ndone = 0;
    repeat (2) begin
      @(negedge clk);
      ndone += done_of(0);
    end
    rst_n = 1'b1;
    repeat (25) begin
      @(negedge clk);
      ndone += done_of(0);
    end
    check("abort_no_done", ndone, 0);
    conv(1'b0, 8888, 16'h8888, 0, "restart");

    // Start held high: one result every BIN_W+2 cycles, value sampled at acceptance.
    @(negedge clk);
    drive(1'b0, 1'b1, 0);
    for (int i = 0; i <= 20; i++) begin
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (done_of(0) == 0 && w < 40);
      check($sformatf("b2b_gap_%0d", i), w, (i == 0) ? 15 : 16);
      check($sformatf("b2b_val_%0d", i), digits(0), to_bcd(i));
      drive(1'b0, (i < 20) ? 1'b1 : 1'b0, i + 1);
    end
    repeat (3) @(negedge clk);
    check("b2b_final_idle", busy_of(0), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
